// File: rtl/complex_pkg.sv
// Shared definitions for the complex rotation datapath.
// Opcodes, sign-bit positions and the rotate/NaN helpers.
package complex_pkg;

    localparam logic [2:0] OP_PASS  = 3'd0;
    localparam logic [2:0] OP_CONJ  = 3'd1;
    localparam logic [2:0] OP_NEG   = 3'd2;
    localparam logic [2:0] OP_NCONJ = 3'd3;
    localparam logic [2:0] OP_J     = 3'd4;
    localparam logic [2:0] OP_NJ    = 3'd5;

    localparam int SIGN_RE = 63;
    localparam int SIGN_IM = 31;

    function automatic logic is_nan32(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Raw sign flips and half swaps; payloads are never touched.
    function automatic logic [63:0] rotate(input logic [63:0] data,
                                           input logic [2:0]  op);
        logic [63:0] m_re;
        logic [63:0] m_im;
        logic [31:0] re;
        logic [31:0] im;
        logic [63:0] res;
        m_re = 64'd1 << SIGN_RE;
        m_im = 64'd1 << SIGN_IM;
        re   = data[63:32];
        im   = data[31:0];
        case (op)
            OP_PASS:  res = data;
            OP_CONJ:  res = data ^ m_im;
            OP_NEG:   res = data ^ m_re ^ m_im;
            OP_NCONJ: res = data ^ m_re;
            OP_J:     res = {im ^ m_im[31:0], re};
            OP_NJ:    res = {im, re ^ m_im[31:0]};
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/complex_pipe_stage.sv
// One valid/ready register stage carrying a rotated word and its flags.
// Loads whenever the ready chain says this slot may advance.
module complex_pipe_stage
    import complex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    input  logic        up_valid_i,
    input  logic [63:0] up_data_i,
    input  logic        up_nan_i,
    input  logic        up_err_i,
    output logic        dn_valid_o,
    output logic [63:0] dn_data_o,
    output logic        dn_nan_o,
    output logic        dn_err_o
);

    logic        v_q;
    logic [63:0] data_q;
    logic        nan_q;
    logic        err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= 64'd0;
            nan_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (rdy_i) begin
            v_q    <= up_valid_i;
            data_q <= up_data_i;
            nan_q  <= up_nan_i;
            err_q  <= up_err_i;
        end
    end

    assign dn_valid_o = v_q;
    assign dn_data_o  = data_q;
    assign dn_nan_o   = nan_q;
    assign dn_err_o   = err_q;

endmodule

// File: rtl/complex_rotator.sv
// Elastic pipelined complex rotator: transform into stage 0,
// then LATENCY-1 pure delay stages with a collapsing ready chain.
module complex_rotator
    import complex_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [2:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_nan,
    output logic        out_err
);

    logic              v [LATENCY+1];
    logic [63:0]       d [LATENCY+1];
    logic              n [LATENCY+1];
    logic              e [LATENCY+1];
    logic [LATENCY:0]  rdy;
    logic [63:0]       rot;

    assign rot  = rotate(in_data, in_op);
    assign v[0] = in_valid;
    assign d[0] = rot;
    assign n[0] = is_nan32(rot[63:32]) || is_nan32(rot[31:0]);
    assign e[0] = in_op[2] & in_op[1];

    // Stage k may advance if it is empty or everything after it moves.
    always_comb begin
        rdy          = '0;
        rdy[LATENCY] = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            rdy[k] = !v[k+1] || rdy[k+1];
        end
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        complex_pipe_stage u_stage (
            .clk       (clk),
            .rst       (rst),
            .rdy_i     (rdy[g]),
            .up_valid_i(v[g]),
            .up_data_i (d[g]),
            .up_nan_i  (n[g]),
            .up_err_i  (e[g]),
            .dn_valid_o(v[g+1]),
            .dn_data_o (d[g+1]),
            .dn_nan_o  (n[g+1]),
            .dn_err_o  (e[g+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[LATENCY];
    assign out_data  = d[LATENCY];
    assign out_nan   = n[LATENCY];
    assign out_err   = e[LATENCY];

endmodule

// File: tb/tb_complex_rotator.sv
// Directed self-checking bench for complex_rotator.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_complex_rotator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_nan;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp6 [6] = '{64'h3F800000_40000000, 64'h3F800000_C0000000,
                              64'hBF800000_C0000000, 64'hBF800000_40000000,
                              64'hC0000000_3F800000, 64'h40000000_BF800000};
    logic [63:0] bp [5]   = '{64'h00000001_00000011, 64'h00000002_00000022,
                              64'h00000003_00000033, 64'h00000004_00000044,
                              64'h00000005_00000055};

    complex_rotator #(.LATENCY(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_nan  (out_nan),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] dat, input logic [2:0] op);
        in_valid = 1'b1;
        in_data  = dat;
        in_op    = op;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_op     = 3'd0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_flags", 64'({out_nan, out_err}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();

        // conjugate latency: accept at edge N, visible after N+3
        push(64'h3F800000_40000000, 3'd1);
        chk("lat_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("lat_v_n0", 64'(out_valid), 64'd0);
        tick();
        chk("lat_v_n1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_v_n2", 64'(out_valid), 64'd0);
        tick();
        chk("lat_v_n3", 64'(out_valid), 64'd1);
        chk("lat_data", out_data, 64'h3F800000_C0000000);
        chk("lat_flags", 64'({out_nan, out_err}), 64'd0);
        tick();
        chk("lat_drained", 64'(out_valid), 64'd0);

        // all six ops back-to-back
        for (int c = 0; c < 10; c++) begin
            if (c < 6) push(64'h3F800000_40000000, 3'(c));
            else in_valid = 1'b0;
            tick();
            if (c >= 3 && c <= 8) begin
                chk($sformatf("b2b_v%0d", c - 3), 64'(out_valid), 64'd1);
                chk($sformatf("b2b_d%0d", c - 3), out_data, exp6[c-3]);
            end else begin
                chk($sformatf("b2b_idle%0d", c), 64'(out_valid), 64'd0);
            end
        end

        // backpressure: four accepts fill the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(bp[i], 3'd0);
            chk($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd1);
            tick();
        end
        push(bp[4], 3'd0);
        chk("bp_full", 64'(in_ready), 64'd0);
        chk("bp_head", out_data, bp[0]);
        tick();
        chk("bp_hold_v", 64'(out_valid), 64'd1);
        chk("bp_hold1", out_data, bp[0]);
        tick();
        chk("bp_hold2", out_data, bp[0]);
        chk("bp_full2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_comb_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_next1", out_data, bp[1]);
        tick();
        chk("bp_still1", out_data, bp[1]);
        out_ready = 1'b1;
        tick();
        chk("bp_next2", out_data, bp[2]);
        tick();
        chk("bp_next3", out_data, bp[3]);
        tick();
        chk("bp_next4", out_data, bp[4]);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // special values
        push(64'h7F800000_7FC00000, 3'd1);
        tick();
        push(64'h80000000_7F800000, 3'd2);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("sp_nan_data", out_data, 64'h7F800000_FFC00000);
        chk("sp_nan_flag", 64'(out_nan), 64'd1);
        tick();
        chk("sp_inf_data", out_data, 64'h00000000_FF800000);
        chk("sp_inf_flag", 64'(out_nan), 64'd0);
        tick();

        // reserved op
        push(64'h12345678_9ABCDEF0, 3'd6);
        tick();
        push(64'h3F800000_40000000, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rsv_data", out_data, 64'h12345678_9ABCDEF0);
        chk("rsv_err", 64'(out_err), 64'd1);
        tick();
        chk("rsv_next_data", out_data, 64'h3F800000_40000000);
        chk("rsv_next_err", 64'(out_err), 64'd0);
        tick();

        // mid-stream asynchronous reset with three words in flight
        push(64'h7FC00000_00000000, 3'd6);
        tick();
        push(64'h00000007_00000007, 3'd0);
        tick();
        push(64'h00000008_00000008, 3'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("mr_pre_v", 64'(out_valid), 64'd1);
        chk("mr_pre_flags", 64'({out_nan, out_err}), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_data", out_data, 64'd0);
        chk("mr_flags", 64'({out_nan, out_err}), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        push(64'h40400000_C0400000, 3'd5);
        tick();
        in_valid = 1'b0;
        chk("mr_post_v0", 64'(out_valid), 64'd0);
        tick();
        chk("mr_post_v1", 64'(out_valid), 64'd0);
        tick();
        chk("mr_post_v2", 64'(out_valid), 64'd0);
        tick();
        chk("mr_post_v3", 64'(out_valid), 64'd1);
        chk("mr_post_data", out_data, 64'hC0400000_C0400000);
        tick();
        chk("mr_alone", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
